// File: rtl/apb4_master.sv
`default_nettype none
// ============================================================================
// apb4_master : single-outstanding valid/ready command -> APB4 transfer engine
// Rev 1.0     : initial release
// ============================================================================
module apb4_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,
  input  logic [2:0]                cmd_prot_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]     paddr_o,
  output logic [2:0]                pprot_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  input  logic                      pready_i,
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pslverr_i
);

  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  localparam bit          TO_EN      = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST    = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  generate
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
      $error("apb4_master: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("apb4_master: TIMEOUT must be in 0..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [15:0]             cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = S_SETUP;
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pprot_d  = cmd_prot_i;
          // Reads drive zero data and strobes onto the bus.
          pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d  = cmd_write_i ? cmd_wstrb_i : '0;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready_i) begin
          state_d       = S_RESP;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d       = S_RESP;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= 16'd0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign paddr_o       = paddr_q;
  assign pprot_o       = pprot_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master.sv
`default_nettype none
// ============================================================================
// tb_apb4_master : scoreboard bench for apb4_master (TIMEOUT = 4)
// Rev 1.0        : initial release
// ============================================================================
module tb_apb4_master;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .cmd_prot_i(cmd_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.to);
      end
    end
  end

  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic slverr, input logic [31:0] rdata, input logic exp_to,
                          input int hold);
    rsp_t        e;
    int          n_acc;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    e.to    = exp_to;
    e.err   = exp_to | slverr;
    e.rdata = (exp_to || wr) ? 32'd0 : rdata;
    exp_wd  = wr ? wdata : 32'd0;
    exp_st  = wr ? strb : 4'd0;
    n_acc   = exp_to ? TIMEOUT : waits + 1;

    rsp_ready = (hold == 0);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_wstrb = strb; cmd_prot = prot;
    sb_q.push_back(e);
    tick();
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom; cmd_wstrb = 4'($urandom);
    // Slave signals outside ACCESS must be ignored.
    pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
    check("setup_sel_en", {psel, penable}, 2'b10);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    check("setup_paddr", paddr, addr);
    tick();
    for (int i = 0; i < n_acc; i++) begin
      check("access_sel_en", {psel, penable}, 2'b11);
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, wr);
      check("access_pwdata", pwdata, exp_wd);
      check("access_pstrb", pstrb, exp_st);
      check("access_pprot", pprot, prot);
      check("access_rsp_valid", rsp_valid, 1'b0);
      if (!exp_to && i == waits) begin
        pready = 1'b1; prdata = rdata; pslverr = slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      tick();
    end
    pready = 1'b0; pslverr = 1'b0;
    check("resp_sel_en", {psel, penable}, 2'b00);
    check("resp_valid", rsp_valid, 1'b1);
    check("resp_cmd_ready", cmd_ready, 1'b0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        cmd_valid = 1'b1; pready = 1'b1; prdata = $urandom; pslverr = 1'($urandom);
        tick();
        check("hold_rsp_valid", rsp_valid, 1'b1);
        check("hold_rdata", rsp_rdata, e.rdata);
        check("hold_err_to", {rsp_err, rsp_timeout}, {e.err, e.to});
        check("hold_psel", psel, 1'b0);
        check("hold_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0; pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
    end
    tick();
    check("after_idle", {cmd_ready, rsp_valid, psel}, 3'b100);
  endtask

  initial begin
    int first, second;
    logic prev;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b1;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) tick();
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 6'd0);
    check("reset_data", {paddr, pwdata}, 64'd0);
    check("reset_misc", {rsp_rdata, pstrb, pprot}, 39'd0);
    rst = 1'b0;
    tick();

    run_xfer(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 1'b0, 0);
    run_xfer(1'b1, 32'h0000_0008, 32'h0000_003C, 4'h3, 3'b001, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b100, 0, 1'b1, 32'h0000_CAFE, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b111, 0, 1'b0, 32'h0000_0BAD, 1'b1, 2);

    pready = 1'b1; prdata = 32'hFEED_F00D;
    repeat (2) begin
      tick();
      check("late_pready_idle", {cmd_ready, rsp_valid, psel}, 3'b100);
    end
    pready = 1'b0;

    run_xfer(1'b1, 32'h0000_000C, 32'h1111_2222, 4'hC, 3'b000, 1, 1'b0, 32'h0, 1'b0, 5);

    // Reset during ACCESS aborts without a response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    tick();
    cmd_valid = 1'b0; pready = 1'b0;
    tick();
    check("rst_pre_access", {psel, penable}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_sel_en", {psel, penable}, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    repeat (2) tick();
    check("rst_stays_idle", {cmd_ready, rsp_valid, psel}, 3'b100);

    // Back-to-back reads with continuous valid/ready.
    pready = 1'b1; prdata = 32'h55AA_00FF; pslverr = 1'b0; rsp_ready = 1'b1;
    sb_q.push_back('{rdata: 32'h55AA_00FF, err: 1'b0, to: 1'b0});
    sb_q.push_back('{rdata: 32'h55AA_00FF, err: 1'b0, to: 1'b0});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010;
    first = -1; second = -1; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (psel && !prev) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      prev = psel;
      if (second >= 0) cmd_valid = 1'b0;
    end
    check("b2b_first_seen", (first >= 0), 1'b1);
    check("b2b_spacing", 64'(second - first), 64'd4);
    pready = 1'b0;
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- APB4 initiator (requester) that converts a single-outstanding valid/ready command stream into APB4 SETUP/ACCESS transfers and returns a valid/ready response.
- It is the driving end of the bus that `apb4_gpio` and the other APB4 peripherals respond to.
- It is used by bus bridges and as the synthesizable stimulus engine in peripheral benches.
- It includes PREADY wait-state handling, PSLVERR capture and a programmable hang timeout.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr_i and paddr_o.
- DATA_WIDTH, 32, data width; must be 8, 16 or 32.
- TIMEOUT, 255, number of ACCESS cycles without pready_i before abort; 0 disables the timeout. The counter is 16 bits wide; maximum value 65535.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accept.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- cmd_wstrb_i  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot_i  in  3  protection attributes.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response accept.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and on timeout.
- rsp_err_o  out  1  pslverr_i sampled, or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- paddr_o  out  ADDR_WIDTH  APB address.
- pprot_o  out  3  APB protection.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pready_i  in  1  slave ready.
- prdata_i  in  DATA_WIDTH  slave read data.
- pslverr_i  in  1  slave error.

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is synchronous and active-high; it is sampled only on the rising edge.
- Reset state:
  - State is IDLE.
  - All outputs are 0 except cmd_ready_o=1 (combinational, from IDLE).
  - The timeout counter is 0.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1; psel_o=0, penable_o=0.
  - A cmd handshake (valid & ready) at edge N registers pwrite, paddr, pprot, pwdata and pstrb, then moves to SETUP.
  - For reads, pwdata_o=0 and pstrb_o=0.
- SETUP (cycle N+1): psel_o=1, penable_o=0. Moves to ACCESS unconditionally.
- ACCESS (cycle N+2 onward):
  - psel_o=1, penable_o=1.
  - All APB outputs are held stable until the state is exited.
  - The counter increments each cycle pready_i=0.
  - If pready_i=1, capture the response and go to RESP:
    - rsp_rdata_o = prdata_i for reads, 0 for writes.
    - rsp_err_o = pslverr_i.
    - rsp_timeout_o = 0.
  - Else, if TIMEOUT!=0 and the counter has reached TIMEOUT-1, abort and go to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - pready_i on the timeout cycle takes priority over the timeout.
- RESP:
  - psel_o=0, penable_o=0, rsp_valid_o=1; rsp_* are held stable.
  - On rsp_ready_i=1, clear rsp_valid_o and go to IDLE; the counter is cleared.
- Latency:
  - Zero-wait-state transfer: command accepted at edge N, rsp_valid_o high from edge N+3.
  - Minimum command-to-command spacing is 4 cycles (one IDLE cycle between transfers).
- Other timing rules:
  - cmd_ready_o=0 in all non-IDLE states; only one transfer is outstanding.
  - pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
  - After a timeout abort, a late pready_i has no effect.
- Reset asserted in any state: at the next edge psel_o and penable_o drop, rsp_valid_o clears, and the FSM enters IDLE. No response is emitted for the aborted transfer.

Test Plan:
- Zero-wait write: cmd addr=0x0000_0004, wdata=0x0000_00A5, wstrb=0xF, pready tied 1.
  - psel at N+1; psel & penable at N+2 with pwrite=1, pwdata=0xA5.
  - rsp_valid at N+3 with err=0, rdata=0.
- 3-wait read: slave holds pready=0 for 3 ACCESS cycles, then returns prdata=0x1234_5678.
  - APB outputs are stable throughout.
  - rsp_rdata=0x1234_5678, err=0; pstrb=0 and pwdata=0 during the transfer.
- Slave error: write with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, pready held 0.
  - After exactly 4 ACCESS cycles psel drops; rsp_err=1, rsp_timeout=1.
  - A later pready pulse is ignored.
- Back-pressure and reset: hold rsp_ready=0 for 5 cycles.
  - rsp stays valid and stable; cmd_ready=0; no new psel.
  - Separately, assert rst_i during ACCESS -> psel and penable are 0 next edge, no rsp_valid, cmd_ready=1.
- Back-to-back: 2 commands are issued continuously with cmd_valid=1 and rsp_ready=1 -> the second psel rises exactly 4 cycles after the first.
